// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
//
// Purpose: divider FSM state encoding, iteration count and operand width,
//          shared by seq_divider, the ALU-side stall logic and the bench.
// Ports:   none (package).
package div_pkg;

  localparam int DATA_W   = 32;
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_e;

  // Two's-complement magnitude of v when it is a negative signed operand.
  function automatic logic [DATA_W-1:0] signed_mag(input logic [DATA_W-1:0] v,
                                                   input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/ready handshake bundle between ALU and divider
//
// Purpose: groups the divider request/response signals.
// Signals: start_i, annul_i, signed_div_i, opdata1_i (dividend),
//          opdata2_i (divisor) from the initiator; ready_o (one-cycle
//          result strobe) and result_o ({remainder, quotient}) back.
// Modports: master = initiator (ALU / bench), slave = seq_divider.
interface seq_divider_if;
  import div_pkg::*;

  logic              start_i;
  logic              annul_i;
  logic              signed_div_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic              ready_o;
  logic [2*DATA_W-1:0] result_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  ready_o, result_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output ready_o, result_o
  );

endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring sequential divider, one quotient bit per cycle
//
// Purpose: 32-bit signed/unsigned division with start/ready handshake.
// Ports:   clk    - clock, rising edge
//          rst    - asynchronous active-low reset
//          flush  - pipeline flush, aborts any operation
//          div_if - slave side of seq_divider_if (operands, start_i,
//                   annul_i, signed_div_i in; ready_o, result_o out)
// Timing:  start captured at edge k -> ready_o high after edge k+33
//          (after edge k+2 for a zero divisor). result_o = {rem, quot}.
module seq_divider #(
  parameter int DIV_ITER = div_pkg::DIV_ITER
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  seq_divider_if.slave div_if
);
  import div_pkg::*;

  localparam logic [5:0] LAST_CNT = 6'(DIV_ITER - 1);

  div_state_e state_q, state_d;

  logic [5:0]        cnt_q;
  // Partial-remainder register:
  //   [64:33] partial remainder, [32] next dividend bit (the two together
  //   form the 33-bit trial window), [31:0] remaining dividend bits shifting
  //   up with quotient bits entering at bit 0. After the last step it holds
  //   {remainder, 1'b0, quotient}.
  logic [64:0]       pr_q;
  logic [DATA_W-1:0] divisor_q;
  logic              neg_quot_q;
  logic              neg_rem_q;

  logic              abort;
  logic              last_step;
  logic [32:0]       trial;
  logic              q_bit;
  logic [31:0]       rem_n;
  logic [31:0]       quo_n;
  logic [31:0]       rem_fix;
  logic [31:0]       quo_fix;
  logic [31:0]       op1_mag;
  logic [31:0]       op2_mag;

  assign abort     = flush | div_if.annul_i;
  assign last_step = (cnt_q == LAST_CNT);

  assign op1_mag = signed_mag(div_if.opdata1_i, div_if.signed_div_i);
  assign op2_mag = signed_mag(div_if.opdata2_i, div_if.signed_div_i);

  // One restoring step: the 33-bit difference's top bit is its sign because
  // the window is always below twice the divisor.
  always_comb begin
    trial   = pr_q[64:32] - {1'b0, divisor_q};
    q_bit   = ~trial[32];
    rem_n   = q_bit ? trial[31:0] : pr_q[63:32];
    quo_n   = {pr_q[30:0], q_bit};
    rem_fix = neg_rem_q  ? (~rem_n + 1'b1) : rem_n;
    quo_fix = neg_quot_q ? (~quo_n + 1'b1) : quo_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (div_if.start_i) begin
          state_d = (div_if.opdata2_i == '0) ? DIVZERO : ON;
        end
      end
      DIVZERO: state_d = END;
      ON: begin
        if (last_step) begin
          state_d = END;
        end
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over a new request and over a pending result.
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      pr_q           <= '0;
      divisor_q      <= '0;
      neg_quot_q     <= 1'b0;
      neg_rem_q      <= 1'b0;
      div_if.ready_o  <= 1'b0;
      div_if.result_o <= '0;
    end else begin
      div_if.ready_o  <= 1'b0;
      div_if.result_o <= '0;
      if (!abort) begin
        case (state_q)
          IDLE: begin
            if (div_if.start_i) begin
              cnt_q      <= '0;
              divisor_q  <= op2_mag;
              neg_quot_q <= div_if.signed_div_i &
                            (div_if.opdata1_i[31] ^ div_if.opdata2_i[31]);
              neg_rem_q  <= div_if.signed_div_i & div_if.opdata1_i[31];
              if (div_if.opdata2_i == '0) begin
                // Divide by zero reports the raw dividend as remainder.
                pr_q <= {div_if.opdata1_i, 1'b0, 32'hFFFF_FFFF};
              end else begin
                pr_q <= {32'd0, op1_mag, 1'b0};
              end
            end
          end
          ON: begin
            cnt_q <= cnt_q + 6'd1;
            if (last_step) begin
              pr_q <= {rem_fix, 1'b0, quo_fix};
            end else begin
              pr_q <= {rem_n, pr_q[31:0], q_bit};
            end
          end
          END: begin
            div_if.ready_o  <= 1'b1;
            div_if.result_o <= {pr_q[64:33], pr_q[31:0]};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
